// File: rtl/fmeter_ctrl.sv
// fmeter_ctrl: sequencer for the reciprocal-counting frequency meter (fmeter).
// Runs in the fs (reference) clock domain. On a start request it pulses
// fm_clr, raises fm_ss, waits for the synchronised fm_sta, times the gate,
// drops fm_ss, waits for fm_sta to fall and settle, then latches the fx/fs
// counts into result registers that are held until the MCU acknowledges.
//
// Ports:
//   clk, rst_n         reference clock, synchronous active-low reset
//   start, gate_len    measurement request and gate length (0 treated as 1)
//   ack                MCU has read the result (clears result_valid)
//   busy               measurement in progress
//   result_valid       result registers hold a new result
//   err_tmo, err_ovf   last measurement timed out / overflowed
//   fm_clr, fm_ss      fmeter clear and start/stop controls
//   fm_sta             fmeter status (fx domain, asynchronous)
//   fm_ovx, fm_ovs     fmeter counter overflow flags
//   fm_cntx, fm_cnts   fmeter counts
//   cntx_q, cnts_q     latched counts
//   gate_used_q        gate length of the reported result (FMC_AUTORANGE_EN only)
//
// Optional build macro FMC_AUTORANGE_EN: on overflow the gate is halved and
// the measurement retried, up to 4 times, before reporting err_ovf.
module fmeter_ctrl #(
  parameter int unsigned CNT_W   = 20,
  parameter int unsigned GATE_W  = 24,
  parameter int unsigned CLR_CYC = 4,
  parameter int unsigned TMO_CYC = 2000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              ack,
  output logic              busy,
  output logic              result_valid,
  output logic              err_tmo,
  output logic              err_ovf,
  output logic              fm_clr,
  output logic              fm_ss,
  input  logic              fm_sta,
  input  logic              fm_ovx,
  input  logic              fm_ovs,
  input  logic [CNT_W-1:0]  fm_cntx,
  input  logic [CNT_W-1:0]  fm_cnts,
  output logic [CNT_W-1:0]  cntx_q,
  output logic [CNT_W-1:0]  cnts_q
`ifdef FMC_AUTORANGE_EN
  ,
  output logic [GATE_W-1:0] gate_used_q
`endif
);

  // One shared cycle counter serves the clear pulse, timeouts and settling.
  localparam int unsigned TMAX = (TMO_CYC > CLR_CYC) ? TMO_CYC : CLR_CYC;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_ARM, S_GATE, S_STOP, S_SETTLE, S_LATCH, S_ABORT, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              sta_s1_q, sta_s_q;
  logic [GATE_W-1:0] gate_len_q, gate_len_d;
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              rv_q, rv_d;
  logic              tmo_q, tmo_d;
  logic              ovf_q, ovf_d;
  logic              clr_q, clr_d;
  logic              ss_q, ss_d;
  logic [CNT_W-1:0]  cntx_d, cnts_d;
  logic              ovf_now;
  logic              do_latch;
`ifdef FMC_AUTORANGE_EN
  logic [2:0]        retry_q, retry_d;
  logic [GATE_W-1:0] gate_used_d;
`endif

  assign ovf_now = fm_ovx | fm_ovs;

  always_comb begin
    state_d    = state_q;
    gate_len_d = gate_len_q;
    gate_cnt_d = gate_cnt_q;
    // Saturating free-run; each state that uses it clears it on entry.
    cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + TW'(1);
    rv_d       = rv_q;
    tmo_d      = tmo_q;
    ovf_d      = ovf_q;
    cntx_d     = cntx_q;
    cnts_d     = cnts_q;
    do_latch   = 1'b0;
`ifdef FMC_AUTORANGE_EN
    retry_d     = retry_q;
    gate_used_d = gate_used_q;
`endif

    if (ack) rv_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          gate_len_d = (gate_len == '0) ? GATE_W'(1) : gate_len;
          tmo_d      = 1'b0;
          ovf_d      = 1'b0;
          cnt_d      = '0;
          state_d    = S_CLR;
`ifdef FMC_AUTORANGE_EN
          retry_d    = '0;
`endif
        end
      end
      S_CLR: begin
        if (cnt_q == TW'(CLR_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (sta_s_q) begin
          // GATE lasts gate_len cycles: count down to zero inclusive.
          gate_cnt_d = gate_len_q - GATE_W'(1);
          state_d    = S_GATE;
        end else if (cnt_q == TW'(TMO_CYC - 1)) begin
          state_d = S_ABORT;
        end
      end
      S_GATE: begin
        if (gate_cnt_q == '0) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          gate_cnt_d = gate_cnt_q - GATE_W'(1);
        end
      end
      S_STOP: begin
        if (!sta_s_q) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else if (cnt_q == TW'(TMO_CYC - 1)) begin
          state_d = S_ABORT;
        end
      end
      S_SETTLE: begin
        if (cnt_q == TW'(1)) state_d = S_LATCH;
      end
      S_LATCH: begin
        do_latch = 1'b1;
`ifdef FMC_AUTORANGE_EN
        if (ovf_now && (gate_len_q > GATE_W'(1)) && (retry_q < 3'd4)) begin
          do_latch   = 1'b0;
          gate_len_d = gate_len_q >> 1;
          retry_d    = retry_q + 3'd1;
          cnt_d      = '0;
          state_d    = S_CLR;
        end
`endif
      end
      S_ABORT: begin
        tmo_d   = 1'b1;
        rv_d    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Set after the ack clear so a same-cycle ack loses.
    if (do_latch) begin
      cntx_d  = fm_cntx;
      cnts_d  = fm_cnts;
      ovf_d   = ovf_now;
      rv_d    = 1'b1;
      state_d = S_DONE;
`ifdef FMC_AUTORANGE_EN
      gate_used_d = gate_len_q;
`endif
    end

    // Outputs are registered copies of the next-state decode.
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    clr_d  = (state_d == S_CLR);
    ss_d   = (state_d == S_ARM) || (state_d == S_GATE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sta_s1_q   <= 1'b0;
      sta_s_q    <= 1'b0;
      gate_len_q <= '0;
      gate_cnt_q <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      rv_q       <= 1'b0;
      tmo_q      <= 1'b0;
      ovf_q      <= 1'b0;
      clr_q      <= 1'b0;
      ss_q       <= 1'b0;
      cntx_q     <= '0;
      cnts_q     <= '0;
`ifdef FMC_AUTORANGE_EN
      retry_q     <= '0;
      gate_used_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sta_s1_q   <= fm_sta;
      sta_s_q    <= sta_s1_q;
      gate_len_q <= gate_len_d;
      gate_cnt_q <= gate_cnt_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      rv_q       <= rv_d;
      tmo_q      <= tmo_d;
      ovf_q      <= ovf_d;
      clr_q      <= clr_d;
      ss_q       <= ss_d;
      cntx_q     <= cntx_d;
      cnts_q     <= cnts_d;
`ifdef FMC_AUTORANGE_EN
      retry_q     <= retry_d;
      gate_used_q <= gate_used_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign err_tmo      = tmo_q;
  assign err_ovf      = ovf_q;
  assign fm_clr       = clr_q;
  assign fm_ss        = ss_q;

endmodule
